// File: rtl/stdp_pkg.sv
// Shared types and constants for the spike timing / STDP path.
// Fixed-point words are unsigned timers and signed time differences.
package stdp_pkg;

    localparam int N_DEF = 32;
    localparam int Q_DEF = 16;

    localparam logic [N_DEF-1:0] FX_ZERO = '0;

    typedef enum logic [1:0] {
        NONE       = 2'd0,
        PRE_ARMED  = 2'd1,
        POST_ARMED = 2'd2,
        BOTH_ARMED = 2'd3
    } arm_state_e;

    function automatic arm_state_e arm_encode(
        input logic pre_armed,
        input logic post_armed
    );
        arm_state_e s;
        case ({pre_armed, post_armed})
            2'b10:   s = PRE_ARMED;
            2'b01:   s = POST_ARMED;
            2'b11:   s = BOTH_ARMED;
            default: s = NONE;
        endcase
        return s;
    endfunction

    function automatic logic arm_has_pre(input arm_state_e s);
        return (s == PRE_ARMED) || (s == BOTH_ARMED);
    endfunction

    function automatic logic arm_has_post(input arm_state_e s);
        return (s == POST_ARMED) || (s == BOTH_ARMED);
    endfunction

endpackage

// File: rtl/saturating_timer.sv
// Elapsed-time accumulator: adds dt per enable, clamps at limit.
// The sum is one bit wider so a carry past the word is seen as saturation.
module saturating_timer
    import stdp_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         enable,
    input  logic [N-1:0] dt,
    input  logic [N-1:0] limit,
    output logic [N-1:0] value,
    output logic         expired
);

    logic [N-1:0] r_value;
    logic [N:0]   w_sum;
    logic [N:0]   w_lim;
    logic [N-1:0] w_next;

    assign w_sum  = {1'b0, r_value} + {1'b0, dt};
    assign w_lim  = {1'b0, limit};
    assign w_next = (w_sum >= w_lim) ? limit : w_sum[N-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_value <= '0;
        end else if (clear) begin
            r_value <= '0;
        end else if (enable) begin
            r_value <= w_next;
        end
    end

    assign value   = r_value;
    assign expired = (r_value >= limit);

endmodule

// File: rtl/spike_timing_tracker.sv
// Pairs pre/post spikes inside a time window and emits t_post - t_pre
// with a one-cycle apply strobe for the downstream STDP stage.
module spike_timing_tracker
    import stdp_pkg::*;
#(
    parameter int           N      = N_DEF,
    parameter int           Q      = Q_DEF,
    parameter logic [N-1:0] WINDOW = 32'h0014_0000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic [N-1:0] dt,
    input  logic         pre_spike,
    input  logic         post_spike,
    output logic [N-1:0] t_change,
    output logic         apply
);

    if (Q >= N) begin : g_bad_q
        $error("Q must be smaller than N");
    end

    localparam logic [N-1:0] L_ZERO = N'(FX_ZERO);

    arm_state_e   r_state;
    arm_state_e   w_state_next;
    logic [N-1:0] r_t_change;
    logic         r_apply;
    logic [N-1:0] w_tc_next;
    logic         w_apply_next;

    logic [N-1:0] w_since_pre;
    logic [N-1:0] w_since_post;
    logic         w_pre_exp;
    logic         w_post_exp;
    logic         w_pre_live;
    logic         w_post_live;
    logic         w_pre_arm_nx;
    logic         w_post_arm_nx;
    logic [N-1:0] w_neg_post;

    saturating_timer #(.N(N)) u_pre_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (pre_spike),
        .enable  (enable),
        .dt      (dt),
        .limit   (WINDOW),
        .value   (w_since_pre),
        .expired (w_pre_exp)
    );

    saturating_timer #(.N(N)) u_post_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (post_spike),
        .enable  (enable),
        .dt      (dt),
        .limit   (WINDOW),
        .value   (w_since_post),
        .expired (w_post_exp)
    );

    // A side counts as armed only while its timer is still below WINDOW,
    // so pairing is strict even in the cycle the timer saturates.
    assign w_pre_live  = arm_has_pre(r_state) && !w_pre_exp;
    assign w_post_live = arm_has_post(r_state) && !w_post_exp;
    assign w_neg_post  = L_ZERO - w_since_post;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= NONE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_tc_next     = r_t_change;
        w_apply_next  = 1'b0;
        w_pre_arm_nx  = pre_spike || w_pre_live;
        w_post_arm_nx = post_spike || w_post_live;
        if (pre_spike && post_spike) begin
            w_tc_next    = L_ZERO;
            w_apply_next = 1'b1;
        end else if (post_spike && w_pre_live) begin
            w_tc_next    = w_since_pre;
            w_apply_next = 1'b1;
        end else if (pre_spike && w_post_live) begin
            w_tc_next    = w_neg_post;
            w_apply_next = 1'b1;
        end
        w_state_next = arm_encode(w_pre_arm_nx, w_post_arm_nx);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_t_change <= L_ZERO;
            r_apply    <= 1'b0;
        end else begin
            r_t_change <= w_tc_next;
            r_apply    <= w_apply_next;
        end
    end

    assign t_change = r_t_change;
    assign apply    = r_apply;

endmodule

// File: tb/tb_spike_timing_tracker.sv
// Directed and randomized checks of spike pairing against a timestamp model.
module tb_spike_timing_tracker;

    localparam int          N   = 32;
    localparam logic [31:0] WIN = 32'h0014_0000;
    localparam logic [31:0] ONE = 32'h0001_0000;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [N-1:0]  dt;
    logic          pre_spike;
    logic          post_spike;
    logic [N-1:0]  t_change;
    logic          apply;

    int total = 0;
    int bad   = 0;

    // Reference: time elapsed since each side's last spike, saturated at WIN.
    longint      m_since_pre;
    longint      m_since_post;
    bit          m_pre_seen;
    bit          m_post_seen;
    logic [31:0] m_tc;
    bit          m_apply;

    spike_timing_tracker #(.N(N), .Q(16), .WINDOW(WIN)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .dt         (dt),
        .pre_spike  (pre_spike),
        .post_spike (post_spike),
        .t_change   (t_change),
        .apply      (apply)
    );

    always #5 clk = ~clk;

    task automatic step(input bit en, input bit pr, input bit po,
                        input bit rs, input logic [31:0] d);
        bit pre_ok;
        bit post_ok;
        longint w;
        enable     = en;
        pre_spike  = pr;
        post_spike = po;
        reset      = rs;
        dt         = d;
        @(posedge clk);
        w = longint'(WIN);
        if (rs) begin
            m_since_pre  = 0;
            m_since_post = 0;
            m_pre_seen   = 0;
            m_post_seen  = 0;
            m_tc         = 32'h0;
            m_apply      = 0;
        end else begin
            pre_ok  = m_pre_seen && (m_since_pre < w);
            post_ok = m_post_seen && (m_since_post < w);
            m_apply = 0;
            if (pr && po) begin
                m_tc    = 32'h0;
                m_apply = 1;
            end else if (po && pre_ok) begin
                m_tc    = 32'(m_since_pre);
                m_apply = 1;
            end else if (pr && post_ok) begin
                m_tc    = 32'(-m_since_post);
                m_apply = 1;
            end
            if (pr) m_pre_seen = 1;
            if (po) m_post_seen = 1;
            if (pr) m_since_pre = 0;
            else if (en) m_since_pre = (m_since_pre + d > w) ? w : m_since_pre + d;
            if (po) m_since_post = 0;
            else if (en) m_since_post = (m_since_post + d > w) ? w : m_since_post + d;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, ONE);
    endtask

    task automatic enables(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, ONE);
    endtask

    task automatic test_reset;
        step(0, 0, 0, 1, ONE);
        step(0, 0, 0, 1, ONE);
        total++;
        if (t_change !== 32'h0 || apply !== 1'b0) begin
            bad++;
            $display("FAIL reset: t_change=%h apply=%b want 0/0", t_change, apply);
        end
    endtask

    task automatic test_pre_post;
        step(0, 0, 0, 1, ONE);
        step(0, 1, 0, 0, ONE);
        enables(5);
        total++;
        if (apply !== 1'b0) begin
            bad++;
            $display("FAIL pre_post_noapply: apply=%b want 0", apply);
        end
        step(0, 0, 1, 0, ONE);
        total++;
        if (apply !== 1'b1 || t_change !== 32'h0005_0000) begin
            bad++;
            $display("FAIL pre_post: apply=%b t=%h want 1/00050000", apply, t_change);
        end
        idle(1);
        total++;
        if (apply !== 1'b0 || t_change !== 32'h0005_0000) begin
            bad++;
            $display("FAIL pre_post_hold: apply=%b t=%h want 0/00050000", apply, t_change);
        end
    endtask

    task automatic test_post_pre;
        step(0, 0, 0, 1, ONE);
        step(0, 0, 1, 0, ONE);
        enables(3);
        step(0, 1, 0, 0, ONE);
        total++;
        if (apply !== 1'b1 || t_change !== 32'hFFFD_0000) begin
            bad++;
            $display("FAIL post_pre: apply=%b t=%h want 1/fffd0000", apply, t_change);
        end
    endtask

    task automatic test_coincident;
        step(0, 0, 0, 1, ONE);
        step(0, 1, 0, 0, ONE);
        enables(7);
        step(1, 1, 1, 0, ONE);
        total++;
        if (apply !== 1'b1 || t_change !== 32'h0) begin
            bad++;
            $display("FAIL coincident: apply=%b t=%h want 1/0", apply, t_change);
        end
        idle(1);
        total++;
        if (apply !== 1'b0) begin
            bad++;
            $display("FAIL coincident_single: apply=%b want 0", apply);
        end
        // Both sides remain armed: a later post pairs with the coincident pre.
        enables(2);
        step(0, 0, 1, 0, ONE);
        total++;
        if (apply !== 1'b1 || t_change !== 32'h0002_0000) begin
            bad++;
            $display("FAIL coincident_rearm: apply=%b t=%h want 1/00020000", apply, t_change);
        end
    endtask

    task automatic test_window;
        step(0, 0, 0, 1, ONE);
        step(0, 1, 0, 0, ONE);
        enables(20);
        step(0, 0, 1, 0, ONE);
        total++;
        if (apply !== 1'b0 || t_change !== 32'h0) begin
            bad++;
            $display("FAIL window_edge: apply=%b t=%h want 0/0", apply, t_change);
        end
        step(0, 0, 0, 1, ONE);
        step(0, 1, 0, 0, ONE);
        enables(19);
        step(0, 0, 1, 0, ONE);
        total++;
        if (apply !== 1'b1 || t_change !== 32'h0013_0000) begin
            bad++;
            $display("FAIL window_inside: apply=%b t=%h want 1/00130000", apply, t_change);
        end
    endtask

    task automatic test_reset_mid;
        step(0, 0, 0, 1, ONE);
        step(0, 1, 0, 0, ONE);
        enables(4);
        step(0, 0, 0, 1, ONE);
        step(0, 0, 1, 0, ONE);
        total++;
        if (apply !== 1'b0 || t_change !== 32'h0) begin
            bad++;
            $display("FAIL reset_mid: apply=%b t=%h want 0/0", apply, t_change);
        end
        // A spike during reset is ignored and leaves nothing armed.
        step(0, 0, 0, 1, ONE);
        step(0, 1, 0, 0, ONE);
        enables(2);
        step(0, 0, 1, 1, ONE);
        total++;
        if (apply !== 1'b0) begin
            bad++;
            $display("FAIL reset_spike: apply=%b want 0", apply);
        end
        step(0, 1, 0, 0, ONE);
        total++;
        if (apply !== 1'b0 || t_change !== 32'h0) begin
            bad++;
            $display("FAIL reset_spike_ignored: apply=%b t=%h want 0/0", apply, t_change);
        end
    endtask

    task automatic test_post_then_pre;
        step(0, 0, 0, 1, ONE);
        step(0, 0, 1, 0, ONE);
        total++;
        if (apply !== 1'b0) begin
            bad++;
            $display("FAIL lone_post: apply=%b want 0", apply);
        end
        step(0, 1, 0, 0, ONE);
        total++;
        if (apply !== 1'b1 || t_change !== 32'h0) begin
            bad++;
            $display("FAIL post_then_pre: apply=%b t=%h want 1/0", apply, t_change);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_t [3];
        exp_t[0] = 32'h0001_0000;
        exp_t[1] = 32'h0002_0000;
        exp_t[2] = 32'h0003_0000;
        step(0, 0, 0, 1, ONE);
        step(0, 1, 0, 0, ONE);
        enables(1);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 1, 0, ONE);
            total++;
            if (apply !== 1'b1 || t_change !== exp_t[i]) begin
                bad++;
                $display("FAIL back_to_back[%0d]: apply=%b t=%h want 1/%h",
                         i, apply, t_change, exp_t[i]);
            end
        end
        step(0, 1, 0, 0, ONE);
        total++;
        if (apply !== 1'b1 || t_change !== 32'h0) begin
            bad++;
            $display("FAIL back_to_back_pre: apply=%b t=%h want 1/0", apply, t_change);
        end
    endtask

    task automatic test_random;
        int errs = 0;
        step(0, 0, 0, 1, ONE);
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(99) < 70,
                 $urandom_range(99) < 8,
                 $urandom_range(99) < 8,
                 $urandom_range(999) < 5,
                 32'($urandom_range(32'h0003_0000, 32'h0000_4000)));
            total++;
            if (apply !== m_apply || t_change !== m_tc) begin
                bad++;
                if (errs < 10)
                    $display("FAIL random[%0d]: apply=%b t=%h want %b/%h",
                             i, apply, t_change, m_apply, m_tc);
                errs++;
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        enable     = 1'b0;
        dt         = ONE;
        pre_spike  = 1'b0;
        post_spike = 1'b0;
        m_since_pre  = 0;
        m_since_post = 0;
        m_pre_seen   = 0;
        m_post_seen  = 0;
        m_tc         = 32'h0;
        m_apply      = 0;
        test_reset();
        test_pre_post();
        test_post_pre();
        test_coincident();
        test_window();
        test_reset_mid();
        test_post_then_pre();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spike_timing_tracker.md
SPIKE_TIMING_TRACKER -- requirements
Module: spike_timing_tracker

Interface
REQ-001 The module SHALL have parameter N, default 32, meaning fixed-point word width.
REQ-002 The module SHALL have parameter Q, default 16, meaning fractional bits of every fixed-point port.
REQ-003 The module SHALL have parameter WINDOW, default 32'h0014_0000 (20.0), meaning pairing window; elapsed time >= WINDOW is unpaired.
REQ-004 The design SHALL use one clock; reset is synchronous and active-high; ports are named clk and reset.
REQ-005 Port clk  input  1  rising-edge clock.
REQ-006 Port reset  input  1  synchronous active-high reset.
REQ-007 Port enable  input  1  timestep strobe; elapsed timers advance only when high.
REQ-008 Port dt  input  N  unsigned fixed-point timestep added per enable.
REQ-009 Port pre_spike  input  1  presynaptic spike, sampled every cycle.
REQ-010 Port post_spike  input  1  postsynaptic spike, sampled every cycle.
REQ-011 Port t_change  output  N  signed fixed-point t_post - t_pre, registered, held until next apply.
REQ-012 Port apply  output  1  one-cycle pulse qualifying t_change for the downstream stdp stage.

Function
REQ-013 Two timers (since_pre, since_post) SHALL each add dt on enable, saturating at WINDOW.
REQ-014 Each timer SHALL be zeroed on its own spike; spike zeroing overrides the same-cycle enable increment.
REQ-015 FSM states SHALL be NONE, PRE_ARMED, POST_ARMED, BOTH_ARMED, tracking which spike has been seen inside WINDOW.
REQ-016 A timer reaching WINDOW SHALL disarm its side (BOTH_ARMED->POST_ARMED or PRE_ARMED; single-armed->NONE).
REQ-017 post_spike alone while pre armed SHALL register t_change = since_pre (pre-increment value), positive.
REQ-018 pre_spike alone while post armed SHALL register t_change = two's-complement negation of since_post, negative.
REQ-019 pre_spike and post_spike in the same cycle SHALL register t_change = 0 with one apply, both sides armed afterwards.
REQ-020 A spike whose opposite side is not armed SHALL only arm its own side; no apply, t_change unchanged.
REQ-021 Pairing comparison SHALL be strict: elapsed < WINDOW pairs; elapsed == WINDOW does not.
REQ-022 apply SHALL rise exactly one cycle after the sampled spike edge and last one cycle; latency 1.
REQ-023 Spikes on consecutive cycles SHALL each produce their own apply; no event is dropped or merged.
REQ-024 Timer arithmetic SHALL use N+1 bits internally so saturation detects overflow before wrap-around.

Reset
REQ-025 On reset: t_change = 0, apply = 0, both timers = 0, state = NONE.
REQ-026 reset asserted mid-operation SHALL drop any pending apply and disarm both sides the next cycle.
REQ-027 Spikes sampled in a reset cycle SHALL be ignored.

Structure
REQ-028 A shared package stdp_pkg SHALL hold the FSM state enum, N/Q default constants and the fixed-point zero constant.
REQ-029 One sub-module, saturating_timer (clear, enable, dt, limit -> value, expired), SHALL be instantiated twice.
REQ-030 The stdp stage SHALL consume t_change and apply directly without glue logic.

Verification (Q=16, dt=32'h0001_0000, WINDOW=20.0)
REQ-031 pre, 5 enables, post -> apply one cycle later, t_change=32'h0005_0000.
REQ-032 post, 3 enables, pre -> apply, t_change=32'hFFFD_0000.
REQ-033 pre and post same cycle -> single apply, t_change=0.
REQ-034 pre, 20 enables, post -> no apply; pre, 19 enables, post -> t_change=32'h0013_0000.
REQ-035 pre, 4 enables, reset, post -> no apply, t_change=0.
REQ-036 post with no prior pre, then pre on the next cycle with no enable between -> first no apply, second apply with t_change=0.
